// File: rtl/rvvi_trace_pkg.sv
// Shared types and version constants for the RVVI trace emitter.
// Optional FPR tracing is enabled by defining RVVI_TRACE_FPR_EN.
package rvvi_trace_pkg;

  localparam int unsigned RVVI_TRACE_VERSION_MAJOR = 1;
  localparam int unsigned RVVI_TRACE_VERSION_MINOR = 4;

  // Control part of a queued retire entry; wide data rides alongside.
  typedef struct packed {
    logic        trap;
    logic        rd_we;
    logic [4:0]  rd;
    logic        csr_we;
    logic [11:0] csr_addr;
`ifdef RVVI_TRACE_FPR_EN
    logic        fd_we;
    logic [4:0]  fd;
`endif
  } ret_ctl_t;

endpackage

// File: rtl/rvvi_trace_fifo.sv
// Retire-entry FIFO with flush; push/pop are gated internally.
// Width-generic; power-of-two DEPTH keeps pointer wrap free.
module rvvi_trace_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rptr];

  // Pointer and occupancy bookkeeping; flush empties in one edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count
             + {{AW{1'b0}}, do_push}
             - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/rvvi_trace_emitter.sv
// Buffers retire events and emits RVVI-style trace pulses with order.
// Define RVVI_TRACE_FPR_EN to add the shadow FP register file.
module rvvi_trace_emitter
  import rvvi_trace_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
`ifdef RVVI_TRACE_FPR_EN
  parameter int unsigned FLEN  = 32,
`endif
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ret_valid,
  output logic            ret_ready,
  input  logic [ILEN-1:0] ret_insn,
  input  logic [XLEN-1:0] ret_pc,
  input  logic            ret_trap,
  input  logic            ret_rd_we,
  input  logic [4:0]      ret_rd,
  input  logic [XLEN-1:0] ret_rd_wdata,
  input  logic            ret_csr_we,
  input  logic [11:0]     ret_csr_addr,
  input  logic [XLEN-1:0] ret_csr_wdata,
`ifdef RVVI_TRACE_FPR_EN
  input  logic            ret_fd_we,
  input  logic [4:0]      ret_fd,
  input  logic [FLEN-1:0] ret_fd_wdata,
  output logic [FLEN-1:0] f_wdata [32],
  output logic [31:0]     f_wb,
`endif
  input  logic            trace_stall,
  input  logic            flush,
  output logic            valid,
  output logic [63:0]     order,
  output logic [ILEN-1:0] insn,
  output logic            trap,
  output logic [XLEN-1:0] pc_rdata,
  output logic [XLEN-1:0] x_wdata [32],
  output logic [31:0]     x_wb,
  output logic            csr_wb,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata
);

  typedef struct packed {
    ret_ctl_t        ctl;
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] csr_wdata;
`ifdef RVVI_TRACE_FPR_EN
    logic [FLEN-1:0] fd_wdata;
`endif
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  entry_t      in_e;
  entry_t      head;
  logic        full;
  logic        empty;
  logic        pop;
  logic        wr_x;
  logic        wr_csr;
  logic [63:0] order_cnt;
`ifdef RVVI_TRACE_FPR_EN
  logic        wr_f;
`endif

  // Pack the retire port into one FIFO word.
  always_comb begin
    in_e              = '0;
    in_e.ctl.trap     = ret_trap;
    in_e.ctl.rd_we    = ret_rd_we;
    in_e.ctl.rd       = ret_rd;
    in_e.ctl.csr_we   = ret_csr_we;
    in_e.ctl.csr_addr = ret_csr_addr;
    in_e.insn         = ret_insn;
    in_e.pc           = ret_pc;
    in_e.rd_wdata     = ret_rd_wdata;
    in_e.csr_wdata    = ret_csr_wdata;
`ifdef RVVI_TRACE_FPR_EN
    in_e.ctl.fd_we    = ret_fd_we;
    in_e.ctl.fd       = ret_fd;
    in_e.fd_wdata     = ret_fd_wdata;
`endif
  end

  rvvi_trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (ret_valid),
    .pop   (pop),
    .din   (in_e),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign ret_ready = !full;
  assign pop       = !empty && !trace_stall && !flush;

  // Traps never commit architectural writes; x0 stays hardwired.
  assign wr_x   = !head.ctl.trap && head.ctl.rd_we
                  && (head.ctl.rd != 5'd0);
  assign wr_csr = !head.ctl.trap && head.ctl.csr_we;
`ifdef RVVI_TRACE_FPR_EN
  assign wr_f   = !head.ctl.trap && head.ctl.fd_we;
`endif

  // Emission register: one pulse per pop, outputs hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= 1'b0;
      order     <= '0;
      order_cnt <= '0;
      insn      <= '0;
      trap      <= 1'b0;
      pc_rdata  <= '0;
      x_wb      <= '0;
      csr_wb    <= 1'b0;
      csr_addr  <= '0;
      csr_wdata <= '0;
      for (int i = 0; i < 32; i++) x_wdata[i] <= '0;
`ifdef RVVI_TRACE_FPR_EN
      f_wb      <= '0;
      for (int i = 0; i < 32; i++) f_wdata[i] <= '0;
`endif
    end else begin
      valid <= pop;
      if (pop) begin
        order     <= order_cnt;
        order_cnt <= order_cnt + 64'd1;
        insn      <= head.insn;
        trap      <= head.ctl.trap;
        pc_rdata  <= head.pc;
        x_wb      <= wr_x ? (32'd1 << head.ctl.rd) : 32'd0;
        if (wr_x) x_wdata[head.ctl.rd] <= head.rd_wdata;
        csr_wb    <= wr_csr;
        if (wr_csr) begin
          csr_addr  <= head.ctl.csr_addr;
          csr_wdata <= head.csr_wdata;
        end
`ifdef RVVI_TRACE_FPR_EN
        f_wb      <= wr_f ? (32'd1 << head.ctl.fd) : 32'd0;
        if (wr_f) f_wdata[head.ctl.fd] <= head.fd_wdata;
`endif
      end
    end
  end

endmodule

// File: doc/rvvi_trace_emitter.md
RVVI_TRACE_EMITTER -- requirements
Module: rvvi_trace_emitter

Interface
REQ-001 SHALL have parameter XLEN, default 32, GPR/CSR/PC width.
REQ-002 SHALL have parameter ILEN, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, retire FIFO entries; power of two, at least 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  interface clock (all state on posedge).
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port ret_valid  in  1  core presents a retired instruction or trap.
REQ-007 SHALL have port ret_ready  out  1  emitter accepts this cycle.
REQ-008 SHALL have port ret_insn  in  ILEN  instruction bits.
REQ-009 SHALL have port ret_pc  in  XLEN  PC of instruction.
REQ-010 SHALL have port ret_trap  in  1  state update without retirement.
REQ-011 SHALL have port ret_rd_we  in  1  GPR write.
REQ-012 SHALL have port ret_rd  in  5  GPR index.
REQ-013 SHALL have port ret_rd_wdata  in  XLEN  GPR value.
REQ-014 SHALL have port ret_csr_we  in  1  CSR write.
REQ-015 SHALL have port ret_csr_addr  in  12  CSR address.
REQ-016 SHALL have port ret_csr_wdata  in  XLEN  CSR value.
REQ-017 SHALL have port trace_stall  in  1  consumer holds off emission.
REQ-018 SHALL have port flush  in  1  discard all queued, not-yet-emitted entries.
REQ-019 SHALL have port valid  out  1  one-cycle event pulse.
REQ-020 SHALL have port order  out  64  event order count.
REQ-021 SHALL have port insn  out  ILEN  instruction bits.
REQ-022 SHALL have port trap  out  1  trap flag.
REQ-023 SHALL have port pc_rdata  out  XLEN  PC.
REQ-024 SHALL have port x_wdata  out  32xXLEN  full shadow GPR file after the event.
REQ-025 SHALL have port x_wb  out  32  one-hot GPR writeback flag.
REQ-026 SHALL have port csr_wb  out  1  CSR writeback flag.
REQ-027 SHALL have port csr_addr  out  12  written CSR address.
REQ-028 SHALL have port csr_wdata  out  XLEN  written CSR value.

Function
REQ-029 SHALL set ret_ready = FIFO not full; accept on ret_valid&&ret_ready at posedge; no pass-through when full, even if popping.
REQ-030 SHALL pop one entry per cycle when FIFO non-empty, !trace_stall, !flush; popped entry drives outputs registered, valid high exactly the next cycle; minimum latency accept edge E -> valid in cycle after edge E+1.
REQ-031 SHALL hold valid low and all other outputs at last emitted values when no pop occurs.
REQ-032 SHALL assign order at emission: first event after reset = 0, +1 per emitted event including traps, no gaps or reuse, wrap 2^64-1 -> 0.
REQ-033 SHALL update the shadow GPR file on emission; x_wb one-hot at ret_rd; write to x0 discarded, x_wb[0] and x_wdata[0] always 0.
REQ-034 SHALL force x_wb=0 and csr_wb=0 on emitted trap entries regardless of captured write enables.
REQ-035 SHALL, on flush: empty FIFO same edge, suppress the pop that cycle, ignore a simultaneous push, keep order and shadow file unchanged.
REQ-036 SHALL allow simultaneous push and pop when not full; occupancy unchanged.

Reset
REQ-037 SHALL on reset clear FIFO, valid=0, order counter=0, x_wdata all 0, x_wb=0, csr_wb=0, csr_addr=0, csr_wdata=0, insn=0, pc_rdata=0, trap=0; reset mid-stream discards queued entries and overrides flush/push.

Configuration
REQ-038 SHALL with RVVI_TRACE_FPR_EN defined add parameter FLEN (default 32), inputs ret_fd_we/ret_fd/ret_fd_wdata and outputs f_wdata (32xFLEN shadow, reset 0) and f_wb (32 one-hot, x0-style exclusion not applied, traps suppress); without it none of these exist.

Structure
REQ-039 SHALL place the FIFO entry struct typedef and RVVI_TRACE version constants in package rvvi_trace_pkg; FIFO SHALL be sub-module rvvi_trace_fifo.

Verification
REQ-040 SHALL cover: reset, push addi x5 (rd=5, wdata=0x10) -> valid 2 cycles later, order=0, x_wb=0x20, x_wdata[5]=0x10.
REQ-041 SHALL cover: trace_stall=1, push 5 entries (DEPTH=4) -> 4 accepted, ret_ready=0 on 5th; release -> 4 pulses, order 0..3.
REQ-042 SHALL cover: write x0 with 0xFFFF -> x_wb=0, x_wdata[0]=0, order still increments.
REQ-043 SHALL cover: trap entry with rd_we=1, csr_we=1 -> trap=1, x_wb=0, csr_wb=0, shadow unchanged.
REQ-044 SHALL cover: 3 queued, flush with simultaneous push -> no valid, next accepted event gets order continuing from last emitted.
REQ-045 SHALL cover: order forced to 2^64-1 via backdoor -> next two events report 2^64-1 then 0.
